// File: rtl/acc_fi_blk.sv
// rtl/acc_fi_blk.sv - block accumulator: sums blk_len signed terms with symmetric saturation
// and presents each block sum through a valid/ready output stage.
module acc_fi_blk #(
  parameter int in_width  = 16,
  parameter int out_width = 24,
  parameter int blk_len   = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [in_width-1:0]  i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [out_width-1:0] o_sum,
  output logic                        o_sat
);

  localparam int cnt_w = $clog2(blk_len);

  // Symmetric limits keep the most negative code out, so a later negation cannot overflow.
  localparam logic signed [out_width:0] pos_lim = {2'b00, {(out_width-1){1'b1}}};
  localparam logic signed [out_width:0] neg_lim = -pos_lim;

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [cnt_w-1:0]            cnt;
  logic signed [out_width-1:0] acc;
  logic                        sticky;
  logic                        take;
  logic                        last_term;
  logic signed [out_width-1:0] base;
  logic signed [out_width:0]   sum_w;
  logic signed [out_width-1:0] sat_val;
  logic                        clamp;

  assign o_ready   = (state == ST_ACC) || i_ready;
  assign take      = i_valid && o_ready;
  assign last_term = (cnt == cnt_w'(blk_len - 1));
  assign o_valid   = (state == ST_OUT);
  assign o_sum     = acc;
  assign o_sat     = sticky;

  // A term arriving together with the output handshake starts a fresh block from zero.
  assign base  = (state == ST_OUT) ? '0 : acc;
  assign sum_w = {base[out_width-1], base}
               + {{(out_width+1-in_width){i_data[in_width-1]}}, i_data};

  always_comb begin
    sat_val = sum_w[out_width-1:0];
    clamp   = 1'b0;
    if (sum_w > pos_lim) begin
      sat_val = pos_lim[out_width-1:0];
      clamp   = 1'b1;
    end else if (sum_w < neg_lim) begin
      sat_val = neg_lim[out_width-1:0];
      clamp   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC: if (take && last_term) state_nxt = ST_OUT;
      ST_OUT: if (i_ready) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      sticky <= 1'b0;
    end else if (state == ST_ACC) begin
      if (take) begin
        acc    <= sat_val;
        sticky <= sticky | clamp;
        cnt    <= last_term ? '0 : cnt + cnt_w'(1);
      end
    end else if (i_ready) begin
      if (i_valid) begin
        acc    <= sat_val;
        sticky <= 1'b0;
        cnt    <= cnt_w'(1);
      end else begin
        acc    <= '0;
        sticky <= 1'b0;
        cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_acc_fi_blk.sv
// tb/tb_acc_fi_blk.sv - scoreboard bench for acc_fi_blk (24-bit and 17-bit instances).
module tb_acc_fi_blk;

  localparam int     BL    = 4;
  localparam longint LIM24 = (longint'(1) << 23) - 1;
  localparam longint LIM17 = (longint'(1) << 16) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic               v = 1'b0, rdy, r, r_man = 1'b1, r_rnd = 1'b1, valid_o, sat;
  logic signed [15:0] d = '0;
  logic signed [23:0] sum;

  logic               v17 = 1'b0, rdy17, r17, r17_man = 1'b1, r17_rnd = 1'b1, valid17, sat17;
  logic signed [15:0] d17 = '0;
  logic signed [16:0] sum17;

  bit rdy_rand = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  longint terms[$], terms17[$], exp_sum[$], exp17_sum[$];
  bit     exp_sat[$], exp17_sat[$];

  assign r   = rdy_rand ? r_rnd   : r_man;
  assign r17 = rdy_rand ? r17_rnd : r17_man;

  acc_fi_blk #(.in_width(16), .out_width(24), .blk_len(BL)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v), .o_ready(rdy), .i_data(d),
    .o_valid(valid_o), .i_ready(r), .o_sum(sum), .o_sat(sat));

  acc_fi_blk #(.in_width(16), .out_width(17), .blk_len(BL)) dut17 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v17), .o_ready(rdy17), .i_data(d17),
    .o_valid(valid17), .i_ready(r17), .o_sum(sum17), .o_sat(sat17));

  always #5 clk = ~clk;

  // Saturating running sum over one block of accepted terms.
  function automatic void ref_block(input longint t[$], input longint lim,
                                    output longint s, output bit st);
    s  = 0;
    st = 1'b0;
    foreach (t[i]) begin
      s = s + t[i];
      if (s > lim) begin s = lim; st = 1'b1; end
      else if (s < -lim) begin s = -lim; st = 1'b1; end
    end
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    r_rnd   = ($urandom_range(0, 3) != 0);
    r17_rnd = ($urandom_range(0, 3) != 0);
  end

  // Stimulus observer: records every accepted term and predicts block results.
  always @(negedge clk) begin
    longint s;
    bit     st;
    #4;
    if (!rst_n) begin
      terms.delete(); exp_sum.delete(); exp_sat.delete();
      terms17.delete(); exp17_sum.delete(); exp17_sat.delete();
    end else begin
      if (v && rdy) begin
        terms.push_back(longint'(d));
        if (terms.size() == BL) begin
          ref_block(terms, LIM24, s, st);
          exp_sum.push_back(s); exp_sat.push_back(st);
          terms.delete();
        end
      end
      if (v17 && rdy17) begin
        terms17.push_back(longint'(d17));
        if (terms17.size() == BL) begin
          ref_block(terms17, LIM17, s, st);
          exp17_sum.push_back(s); exp17_sat.push_back(st);
          terms17.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    #4;
    if (rst_n && valid_o && r) begin
      if (exp_sum.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_out: got sum %0d expected no output", longint'(sum));
      end else begin
        chk("blk_sum", longint'(sum), exp_sum.pop_front());
        chk("blk_sat", longint'(sat), longint'(exp_sat.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    #4;
    if (rst_n && valid17 && r17) begin
      if (exp17_sum.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_out17: got sum %0d expected no output", longint'(sum17));
      end else begin
        chk("blk17_sum", longint'(sum17), exp17_sum.pop_front());
        chk("blk17_sat", longint'(sat17), longint'(exp17_sat.pop_front()));
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the term is taken.
  task automatic send(input int which, input longint x);
    int n = 0;
    bit ok = 1'b0;
    if (which == 0) begin v = 1'b1; d = 16'(x); end
    else begin v17 = 1'b1; d17 = 16'(x); end
    while (!ok) begin
      #4;
      ok = (which == 0) ? rdy : rdy17;
      @(negedge clk);
      n++;
      if (!ok && n > 500) begin
        vectors++; miscompares++;
        $display("FAIL send_timeout: got no accept expected accept within 500 cycles");
        break;
      end
    end
    if (which == 0) v = 1'b0; else v17 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_drive(input int which, input int nblk);
    logic signed [15:0] tmp;
    for (int i = 0; i < nblk * BL; i++) begin
      repeat ($urandom_range(0, 2)) begin
        if (which == 0) d = 16'($urandom); else d17 = 16'($urandom);
        @(negedge clk);
      end
      case ($urandom_range(0, 5))
        0:       tmp = 16'sh7fff;
        1:       tmp = 16'sh8000;
        default: tmp = 16'($urandom);
      endcase
      send(which, longint'(tmp));
    end
  endtask

  initial begin
    int w;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", longint'(valid_o), 0);
    chk("rst_sum", longint'(sum), 0);
    chk("rst_sat", longint'(sat), 0);
    chk("rst_valid17", longint'(valid17), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_ready", longint'(rdy), 1);
    @(negedge clk);

    for (int i = 1; i <= 4; i++) send(0, i);
    #1 chk("latency_valid", longint'(valid_o), 1);
    @(negedge clk);
    idle(1);

    repeat (4) send(0, -32768);
    idle(2);

    repeat (4) send(1, 32767);
    idle(2);
    repeat (4) send(1, -32768);
    idle(2);

    r_man = 1'b0;
    for (int i = 1; i <= 4; i++) send(0, i * 10);
    v = 1'b1; d = 16'sd99;
    for (int i = 0; i < 5; i++) begin
      #4;
      chk("stall_ready", longint'(rdy), 0);
      chk("stall_valid", longint'(valid_o), 1);
      chk("stall_sum", longint'(sum), 100);
      @(negedge clk);
    end
    r_man = 1'b1; d = 16'sd7;
    @(negedge clk);
    v = 1'b0;
    repeat (3) send(0, 1);
    idle(2);

    send(0, 3); send(0, 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", longint'(valid_o), 0);
    chk("midrst_sum", longint'(sum), 0);
    chk("midrst_sat", longint'(sat), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (4) send(0, 5);
    idle(2);

    r_man = 1'b0;
    for (int i = 1; i <= 4; i++) send(0, i);
    #1 chk("outrst_pre_valid", longint'(valid_o), 1);
    rst_n = 1'b0;
    #1 chk("outrst_valid", longint'(valid_o), 0);
    @(negedge clk);
    rst_n = 1'b1; r_man = 1'b1;
    idle(3);
    chk("outrst_no_emit", longint'(valid_o), 0);

    rdy_rand = 1'b1;
    fork
      rand_drive(0, 1000);
      rand_drive(1, 200);
    join
    rdy_rand = 1'b0;
    w = 0;
    while ((exp_sum.size() + exp17_sum.size()) != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drained", longint'(exp_sum.size() + exp17_sum.size()), 0);
    chk("no_partial", longint'(terms.size() + terms17.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/acc_fi_blk.md
ACC_FI_BLK -- requirements
Module: acc_fi_blk

Interface
REQ-001 SHALL have parameter in_width, default 16, meaning signed two's-complement width of each input term.
REQ-002 SHALL have parameter out_width, default 24, meaning signed width of the block sum; out_width >= in_width+1.
REQ-003 SHALL have parameter blk_len, default 32, meaning number of terms summed per block; blk_len >= 2.
REQ-004 SHALL have one clock and an asynchronous active-low reset: i_clk  input  1  clock, all state rising-edge.
REQ-005 SHALL have i_rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have i_valid  input  1  upstream term valid.
REQ-007 SHALL have o_ready  output  1  block can accept a term this cycle.
REQ-008 SHALL have i_data  input  in_width  signed term.
REQ-009 SHALL have o_valid  output  1  block sum valid.
REQ-010 SHALL have i_ready  input  1  downstream (fixed-point to bf16 stage) accepts the sum.
REQ-011 SHALL have o_sum  output  out_width  signed saturated block sum, directly consumable as the fixed-point input of the bf16 conversion stage.
REQ-012 SHALL have o_sat  output  1  sticky flag: saturation occurred within the block being presented.

Function
REQ-013 SHALL implement two states: ACC (collecting terms) and OUT (presenting sum).
REQ-014 SHALL transfer a term only when i_valid && o_ready on a rising edge; no term is lost or counted twice.
REQ-015 SHALL keep a term counter of width $clog2(blk_len), holding the number of terms accepted in the current block.
REQ-016 SHALL, on each accepted term, set acc <= sat(acc + sign-extended i_data), with the addition performed at out_width+1 bits.
REQ-017 SHALL clamp to the symmetric range [-(2^(out_width-1)-1), +(2^(out_width-1)-1)]; the most negative code is never produced, so the downstream negation cannot overflow.
REQ-018 SHALL set the sticky saturation bit whenever a clamp occurs, and carry it into o_sat for that block.
REQ-019 SHALL move ACC->OUT on acceptance of the blk_len-th term; o_valid rises the following cycle, so latency is 1 cycle from the last term.
REQ-020 SHALL drive o_sum/o_sat from registers, stable while o_valid=1 and i_ready=0.
REQ-021 SHALL drive o_ready = (state==ACC) || (state==OUT && i_ready); the ready path is combinational on i_ready only.
REQ-022 SHALL, on output handshake (o_valid && i_ready) with no simultaneous term, clear acc, counter and sticky bit, deassert o_valid, and return to ACC.
REQ-023 SHALL, on output handshake with a simultaneous term, load acc <= sat(i_data) (sticky bit = 0), set counter=1, and return to ACC; this gives zero-bubble back-to-back blocks.
REQ-024 SHALL treat i_data as don't-care when i_valid=0; i_valid deasserting mid-block only pauses accumulation.
REQ-025 SHALL set o_valid=0 in ACC at all times.

Reset
REQ-026 SHALL, while i_rst_n=0 (asynchronous), force state=ACC, acc=0, counter=0, sticky=0, o_valid=0, o_sum=0, o_sat=0; o_ready=1 from the first edge after release.
REQ-027 SHALL, if reset is asserted mid-block or in OUT, discard the partial or pending sum with no output emitted.

Verification (in_width=16, out_width=24, blk_len=4)
REQ-028 SHALL pass: terms 1,2,3,4 on consecutive cycles -> o_valid next cycle, o_sum=10, o_sat=0.
REQ-029 SHALL pass: terms -32768 x4 -> o_sum=-131072 (0xFE0000), o_sat=0; then the converter produces bf16 0xC800.
REQ-030 SHALL pass with out_width=17: terms 32767 x4 -> o_sum=65535, o_sat=1; terms -32768 x4 -> o_sum=-65535, o_sat=1.
REQ-031 SHALL pass: i_ready held 0 for 5 cycles after o_valid -> o_sum stable, o_ready=0, and i_valid terms are not accepted; then i_ready=1 with a term 7 presented -> next block starts with acc=7, counter=1.
REQ-032 SHALL pass: random i_valid/i_ready gaps over 1000 blocks -> every o_sum equals the reference model saturated sum, with no dropped or duplicated terms.
REQ-033 SHALL pass: i_rst_n pulsed low after 2 of 4 terms -> outputs 0 immediately; the next 4 terms 5,5,5,5 give o_sum=20.
